// File: rtl/conv_row_writer_if.sv
// Row transfer bundle from the convolution datapath into the row writer.
// Producer drives row_valid/row_data; consumer drives row_ready.
interface conv_row_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OW         = 44
);
    logic                       row_valid;
    logic                       row_ready;
    logic [0:OW*DATA_WIDTH-1]   row_data;

    modport master (output row_valid, output row_data, input row_ready);
    modport slave  (input row_valid, input row_data, output row_ready);
endinterface

// File: rtl/conv_row_writer.sv
// Assembles convolution output rows into a flat feature map and requests rows in order.
// Latency: a row lands in image_out on its accept edge. Backpressure: row_ready only while collecting.
module conv_row_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int H          = 48,
    parameter int W          = 48,
    parameter int F          = 5,
    localparam int OH        = H - F + 1,
    localparam int OW        = W - F + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    conv_row_writer_if.slave                row,
    output logic [5:0]                      row_number,
    output logic                            busy,
    output logic                            done,
    output logic [0:OH*OW*DATA_WIDTH-1]     image_out
);
    localparam int         ROW_BITS = OW * DATA_WIDTH;
    localparam logic [5:0] LAST_ROW = 6'(OH - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t state;
    state_t state_nxt;
    logic   xfer;
    logic   last_row;

    assign xfer     = (state == COLLECT) && row.row_valid;
    assign last_row = (row_number == LAST_ROW);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)             state_nxt = COLLECT;
            COLLECT: if (xfer && last_row)  state_nxt = DONE;
            DONE:    if (start)             state_nxt = COLLECT;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Handshake and status are pure state decodes, so no input reaches an output combinationally.
    always_comb begin
        row.row_ready = (state == COLLECT);
        busy          = (state == COLLECT);
        done          = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_number <= '0;
            image_out  <= '0;
        end else if (xfer) begin
            image_out[int'(row_number) * ROW_BITS +: ROW_BITS] <= row.row_data;
            if (!last_row) begin
                row_number <= row_number + 6'd1;
            end
        end else if ((state != COLLECT) && start) begin
            row_number <= '0;
            image_out  <= '0;
        end
    end
endmodule

// File: tb/tb_conv_row_writer.sv
// Bench for conv_row_writer: directed table, hand-written corner sequences and random traffic vs a row-array model.
module tb_conv_row_writer;
    localparam int DW   = 8;
    localparam int H    = 6;
    localparam int W    = 6;
    localparam int F    = 3;
    localparam int OH   = H - F + 1;
    localparam int OW   = W - F + 1;
    localparam int ROWW = OW * DW;
    localparam int IMGW = OH * OW * DW;

    logic            clk;
    logic            reset;
    logic            start;
    logic [5:0]      row_number;
    logic            busy;
    logic            done;
    logic [0:IMGW-1] image_out;

    conv_row_writer_if #(.DATA_WIDTH(DW), .OW(OW)) rif ();

    conv_row_writer #(.DATA_WIDTH(DW), .H(H), .W(W), .F(F)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .row        (rif),
        .row_number (row_number),
        .busy       (busy),
        .done       (done),
        .image_out  (image_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: rows kept as a 2-D array, status as two flags.
    bit          m_col;
    bit          m_done;
    int          m_rn;
    logic [7:0]  m_img [OH][OW];

    typedef struct {
        bit         rst;
        bit         st;
        bit         vl;
        int         drow;
        bit         e_ready;
        bit         e_busy;
        bit         e_done;
        logic [5:0] e_rn;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [IMGW-1:0] act, input logic [IMGW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [0:ROWW-1] row_pat(input int r);
        logic [0:ROWW-1] d;
        for (int c = 0; c < OW; c++) d[c*DW +: DW] = 8'(16 * r + c);
        return d;
    endfunction

    function automatic logic [0:ROWW-1] row_fill(input logic [7:0] v);
        logic [0:ROWW-1] d;
        for (int c = 0; c < OW; c++) d[c*DW +: DW] = v;
        return d;
    endfunction

    function automatic logic [0:IMGW-1] img_pat();
        logic [0:IMGW-1] m;
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) m[(r*OW + c)*DW +: DW] = 8'(16 * r + c);
        return m;
    endfunction

    function automatic logic [0:IMGW-1] img_fill(input logic [7:0] v);
        logic [0:IMGW-1] m;
        for (int i = 0; i < OH * OW; i++) m[i*DW +: DW] = v;
        return m;
    endfunction

    function automatic logic [7:0] elem(input logic [0:IMGW-1] img, input int r, input int c);
        return img[(r*OW + c)*DW +: DW];
    endfunction

    function automatic logic [0:IMGW-1] model_image();
        logic [0:IMGW-1] m;
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) m[(r*OW + c)*DW +: DW] = m_img[r][c];
        return m;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) m_img[r][c] = 8'h00;
    endtask

    task automatic model_edge(input bit rst, input bit st, input bit vl, input logic [0:ROWW-1] d);
        if (rst) begin
            m_col = 0; m_done = 0; m_rn = 0;
            model_clear();
        end else if (m_col) begin
            if (vl) begin
                for (int c = 0; c < OW; c++) m_img[m_rn][c] = d[c*DW +: DW];
                if (m_rn == OH - 1) begin
                    m_col = 0; m_done = 1;
                end else begin
                    m_rn++;
                end
            end
        end else if (st) begin
            m_col = 1; m_done = 0; m_rn = 0;
            model_clear();
        end
    endtask

    task automatic check_model();
        chk("model_ready", IMGW'(rif.row_ready), IMGW'(m_col));
        chk("model_busy",  IMGW'(busy),          IMGW'(m_col));
        chk("model_done",  IMGW'(done),          IMGW'(m_done));
        chk("model_rownum", IMGW'(row_number),   IMGW'(m_rn));
        chk("model_image", image_out,            model_image());
    endtask

    task automatic cycle(input bit rst, input bit st, input bit vl, input logic [0:ROWW-1] d);
        reset         = rst;
        start         = st;
        rif.row_valid = vl;
        rif.row_data  = d;
        @(posedge clk);
        model_edge(rst, st, vl, d);
        #1;
        check_model();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rif.row_valid = 1'b0; rif.row_data = '0;
        m_col = 0; m_done = 0; m_rn = 0;
        model_clear();

        //                rst st vl drow  rdy busy done rn
        tbl[0] = '{1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0, 6'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 0,  1'b1, 1'b1, 1'b0, 6'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 0,  1'b1, 1'b1, 1'b0, 6'd1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0, 6'd2};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b0, 6'd3};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 3,  1'b0, 1'b0, 1'b1, 6'd3};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b0, 1'b1, 6'd3};

        // Reset, then idle with row_valid high: nothing may move.
        cycle(1, 0, 0, '0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, row_fill(8'h5A));
            chk("idle_ready", IMGW'(rif.row_ready), '0);
            chk("idle_busy",  IMGW'(busy),          '0);
            chk("idle_done",  IMGW'(done),          '0);
            chk("idle_rownum", IMGW'(row_number),   '0);
            chk("idle_image", image_out,            '0);
        end

        // Back-to-back frame from the table.
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].rst, tbl[i].st, tbl[i].vl, row_pat(tbl[i].drow));
            chk("tbl_ready",  IMGW'(rif.row_ready), IMGW'(tbl[i].e_ready));
            chk("tbl_busy",   IMGW'(busy),          IMGW'(tbl[i].e_busy));
            chk("tbl_done",   IMGW'(done),          IMGW'(tbl[i].e_done));
            chk("tbl_rownum", IMGW'(row_number),    IMGW'(tbl[i].e_rn));
        end
        chk("elem_3_2", IMGW'(elem(image_out, 3, 2)), IMGW'(8'h32));
        chk("b2b_image", image_out, img_pat());

        // Upstream stall between rows 1 and 2.
        cycle(0, 1, 0, '0);
        cycle(0, 0, 1, row_pat(0));
        cycle(0, 0, 1, row_pat(1));
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, row_pat(2));
            chk("stall_rownum", IMGW'(row_number), IMGW'(6'd2));
        end
        cycle(0, 0, 1, row_pat(2));
        cycle(0, 0, 1, row_pat(3));
        chk("stall_done",  IMGW'(done), IMGW'(1'b1));
        chk("stall_image", image_out, img_pat());

        // start mid-frame is ignored.
        cycle(0, 1, 0, '0);
        cycle(0, 0, 1, row_pat(0));
        cycle(0, 0, 1, row_pat(1));
        cycle(0, 1, 0, '0);
        chk("midstart_rownum", IMGW'(row_number), IMGW'(6'd2));
        chk("midstart_busy",   IMGW'(busy),       IMGW'(1'b1));
        cycle(0, 0, 1, row_pat(2));
        cycle(0, 0, 1, row_pat(3));
        chk("midstart_done",  IMGW'(done), IMGW'(1'b1));
        chk("midstart_image", image_out, img_pat());

        // Reset mid-frame discards partial data; then an all-AA frame.
        cycle(0, 1, 0, '0);
        cycle(0, 0, 1, row_pat(0));
        cycle(0, 0, 1, row_pat(1));
        cycle(1, 0, 1, row_pat(2));
        chk("rst_image",  image_out,          '0);
        chk("rst_rownum", IMGW'(row_number),  '0);
        chk("rst_busy",   IMGW'(busy),        '0);
        chk("rst_done",   IMGW'(done),        '0);
        cycle(0, 1, 0, '0);
        for (int r = 0; r < OH; r++) cycle(0, 0, 1, row_fill(8'hAA));
        chk("aa_image", image_out, img_fill(8'hAA));
        chk("aa_done",  IMGW'(done), IMGW'(1'b1));

        // Restart from DONE with row_valid in the start cycle.
        cycle(0, 1, 1, row_fill(8'h55));
        chk("restart_image",  image_out,         '0);
        chk("restart_rownum", IMGW'(row_number), '0);
        chk("restart_done",   IMGW'(done),       '0);
        chk("restart_busy",   IMGW'(busy),       IMGW'(1'b1));
        cycle(0, 0, 1, row_fill(8'h55));
        chk("restart_rownum1", IMGW'(row_number), IMGW'(6'd1));
        chk("restart_elem00",  IMGW'(elem(image_out, 0, 0)), IMGW'(8'h55));
        chk("restart_elem10",  IMGW'(elem(image_out, 1, 0)), '0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [0:ROWW-1] d;
            d = ROWW'($urandom);
            cycle($urandom_range(59) == 0, $urandom_range(7) == 0, $urandom_range(1) == 1, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_row_writer.md
Name: conv_row_writer

Overview:
- Write-back end of the convolution row path: the receptive-field selector reads input rows out of a flat image; this block writes the resulting convolution output rows back into a flat output feature map.
- Issues the row index the datapath must process next.
- Accepts one output row per valid/ready handshake and stores it at that row's position.
- Raises done once all H-F+1 rows are stored, which hands the assembled map to the next layer.

Parameters:
- DATA_WIDTH, 32: width of one output element.
- H, 48: input image height.
- W, 48: input image width.
- F, 5: filter size. Derived: OH = H-F+1 output rows; OW = W-F+1 output columns.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins collection of a new frame.
- row_valid  in  1  row_data holds a complete output row.
- row_ready  out  1  block accepts a row this cycle.
- row_data  in  [0:OW*DATA_WIDTH-1]  one output row; element c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- row_number  out  6  index of the row expected next; drives the selector's rowNumber.
- busy  out  1  high while collecting.
- done  out  1  frame complete; output map valid.
- image_out  out  [0:OH*OW*DATA_WIDTH-1]  output feature map; element (r,c) at bits [(r*OW+c)*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: state=IDLE; row_ready=0; busy=0; done=0; row_number=0; image_out=all zero.
- States: IDLE, COLLECT, DONE. The FSM is registered; all outputs are registered or decoded from state only, with no combinational path from inputs to outputs.
- row_ready = (state==COLLECT). busy = (state==COLLECT). done = (state==DONE).
- IDLE:
  - start=1 -> COLLECT on the next edge; row_number<=0; image_out<=0.
  - row_valid is ignored.
- COLLECT:
  - Handshake: a row transfers on an edge where row_valid && row_ready.
  - On transfer: image_out[row_number*OW*DATA_WIDTH +: OW*DATA_WIDTH] <= row_data.
  - If row_number==OH-1: go to DONE; row_number is held at OH-1.
  - Otherwise: row_number<=row_number+1.
  - No transfer: all state is held.
  - start is ignored; no restart mid-frame.
- DONE:
  - image_out and row_number are held; row_valid is ignored.
  - start=1 -> COLLECT; row_number<=0; image_out<=0; done falls on the same edge.
- Latency:
  - The accepted row appears in image_out on the edge that samples the handshake.
  - done rises on the edge that accepts row OH-1.
  - Minimum frame: 1 cycle for start plus OH cycles of rows.
- Width rules:
  - row_number is 6 bits, so OH must be <= 64; this holds for defaults (OH=44).
  - Offset arithmetic uses integer width, not the 6-bit port width.
- Boundaries:
  - row_valid asserted in the same cycle as start: no transfer, because row_ready is still 0.
  - Upstream stall (row_valid=0) for any number of cycles: no state change.
  - Back-to-back rows: one row per cycle at full rate.
  - reset during COLLECT or DONE: return to IDLE with all outputs at reset values; partial data is discarded.
  - OH==1: the first accepted row goes directly to DONE.

Test Plan:
- Use DATA_WIDTH=8, H=W=6, F=3, so OH=OW=4. Cover the cases below.
- Reset, then hold start=0 and row_valid=1 for 10 cycles -> row_ready=0, busy=0, done=0, row_number=0, image_out=0 throughout.
- Pulse start, then send 4 back-to-back rows with element (r,c)=8'h10*r+c -> row_number steps 0,1,2,3; done rises on the 4th accept edge; element (3,2) of image_out = 8'h32; busy=0 afterwards.
- Same frame with row_valid low for 3 cycles between rows 1 and 2 -> row_number holds at 2 through the stall; final image_out is identical to the back-to-back case.
- start pulsed during COLLECT after 2 rows -> ignored; row_number stays 2; frame completes normally.
- Assert reset after 2 accepted rows -> next cycle state is IDLE, image_out=0, row_number=0; a new start and 4 rows of 8'hAA produce every element = 8'hAA.
- In DONE, pulse start with row_valid=1 in the same cycle -> image_out clears and row_number=0; first transfer occurs on the following cycle; done=0.
